// File: rtl/uninasoc_irq_pkg.sv
// uninasoc_irq_pkg: shared interrupt constants for the PLIC wrapper and source conditioning
package uninasoc_irq_pkg;

   localparam int NUM_SRC                 = 32;
   localparam int IRQ_SYNC_STAGES_DEFAULT = 2;
   localparam int IRQ_FILTER_LEN_DEFAULT  = 4;

   // Counter must hold 0..FILTER_LEN-1 and never collapse to a zero-width vector
   function automatic int irq_cnt_width(input int filter_len);
      return ($clog2(filter_len + 1) > 1) ? $clog2(filter_len + 1) : 1;
   endfunction

endpackage

// File: rtl/irq_src_filter.sv
// irq_src_filter: one interrupt source -- synchronizer, glitch filter and edge pulse
module irq_src_filter
   import uninasoc_irq_pkg::*;
#(
   parameter int SYNC_STAGES = IRQ_SYNC_STAGES_DEFAULT,
   parameter int FILTER_LEN  = IRQ_FILTER_LEN_DEFAULT,
   parameter bit EDGE        = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic src_async_i,
   input  logic en_i,
   output logic stable_o,
   output logic pulse_o
);

   localparam int CW = irq_cnt_width(FILTER_LEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN > 1 ? FILTER_LEN - 1 : 0);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   stable_q, stable_d;
   logic                   pulse_q, pulse_d;
   logic                   diff, last;

   // A pulse fires only on the edge where the filtered level actually flips 0->1
   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], src_async_i};
      diff     = sync_q[SYNC_STAGES-1] ^ stable_q;
      last     = (FILTER_LEN <= 1) || (cnt_q == CNT_LAST);
      stable_d = stable_q ^ (diff && last);
      cnt_d    = (diff && !last) ? cnt_q + 1'b1 : '0;
      pulse_d  = EDGE && diff && last && !stable_q && en_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
         pulse_q  <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         pulse_q  <= pulse_d;
      end
   end

   assign stable_o = stable_q;
   assign pulse_o  = pulse_q;

endmodule

// File: rtl/irq_src_conditioner.sv
// irq_src_conditioner: per-source synchronize/filter of raw interrupt lines feeding the PLIC
module irq_src_conditioner #(
   parameter int                                      NUM_SRC         = uninasoc_irq_pkg::NUM_SRC,
   parameter int                                      SYNC_STAGES     = uninasoc_irq_pkg::IRQ_SYNC_STAGES_DEFAULT,
   parameter int                                      FILTER_LEN      = uninasoc_irq_pkg::IRQ_FILTER_LEN_DEFAULT,
   parameter logic [NUM_SRC-1:0]                      LEVEL_EDGE_TRIG = '0
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_SRC-1:0] src_async_i,
   input  logic [NUM_SRC-1:0] src_en_i,
   output logic [NUM_SRC-1:0] intr_src_o,
   output logic [NUM_SRC-1:0] src_level_o
);

   logic [NUM_SRC-1:0] stable, pulse;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      irq_src_filter #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILTER_LEN  (FILTER_LEN),
         .EDGE        (LEVEL_EDGE_TRIG[i])
      ) u_filt (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .src_async_i (src_async_i[i]),
         .en_i        (src_en_i[i]),
         .stable_o    (stable[i]),
         .pulse_o     (pulse[i])
      );
      assign intr_src_o[i] = LEVEL_EDGE_TRIG[i] ? pulse[i] : stable[i] & src_en_i[i];
   end

   assign src_level_o = stable;

endmodule

// File: tb/tb_irq_src_conditioner.sv
// tb_irq_src_conditioner: directed and randomized checks against a window-based reference model
module tb_irq_src_conditioner;

   localparam int          N   = 32;
   localparam int          S   = 2;
   localparam int          F   = 4;
   localparam int          L   = S + F;
   localparam logic [31:0] LET = 32'h0000_0080;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  src, en;
   logic [N-1:0]  intr_src_o, src_level_o;

   int checks = 0;
   int errors = 0;

   logic [31:0] samp_q[$];
   logic [31:0] stable_m, pulse_m;

   always #5 clk = ~clk;

   irq_src_conditioner #(
      .NUM_SRC         (N),
      .SYNC_STAGES     (S),
      .FILTER_LEN      (F),
      .LEVEL_EDGE_TRIG (LET)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .src_async_i (src),
      .src_en_i    (en),
      .intr_src_o  (intr_src_o),
      .src_level_o (src_level_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      samp_q.delete();
      repeat (L) samp_q.push_back('0);
      stable_m = '0;
      pulse_m  = '0;
   endtask

   // The filtered level flips to v once the last F synchronized samples (input S edges ago) all equal v
   task automatic model_edge();
      logic [31:0] nxt_p;
      logic        want, held;
      if (rst) model_reset();
      else begin
         samp_q.push_back(src);
         samp_q.delete(0);
         nxt_p = '0;
         for (int i = 0; i < N; i++) begin
            want = !stable_m[i];
            held = 1'b1;
            for (int j = 0; j < F; j++)
               if (samp_q[samp_q.size() - 1 - S - j][i] != want) held = 1'b0;
            if (held) begin
               stable_m[i] = want;
               nxt_p[i]    = want & en[i];
            end
         end
         pulse_m = nxt_p;
      end
   endtask

   function automatic logic [31:0] exp_irq();
      return (pulse_m & LET) | (stable_m & en & ~LET);
   endfunction

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      chk({tag, "_lvl"}, src_level_o, stable_m);
      chk({tag, "_irq"}, intr_src_o, exp_irq());
   endtask

   task automatic reset_now(input string tag);
      rst = 1'b1;
      #1;
      chk({tag, "_lvl"}, src_level_o, '0);
      chk({tag, "_irq"}, intr_src_o, '0);
      model_reset();
   endtask

   initial begin
      src = '0;
      en  = '0;
      reset_now("rst");
      tick("rst_hold");
      tick("rst_hold");
      rst = 1'b0;
      repeat (3) tick("idle");

      en     = '1;
      src[3] = 1'b1;
      for (int k = 1; k <= L; k++) begin
         tick("rise");
         chk("rise_lvl3", 32'(src_level_o[3]), 32'(k == L));
         chk("rise_irq3", 32'(intr_src_o[3]), 32'(k == L));
      end
      src[3] = 1'b0;
      repeat (L) tick("fall");
      chk("fall_lvl3", 32'(src_level_o[3]), 32'd0);

      src[3] = 1'b1;
      repeat (F - 1) tick("glitch");
      src[3] = 1'b0;
      for (int k = 0; k < L + 2; k++) begin
         tick("glitch_tail");
         chk("glitch_lvl", src_level_o, '0);
         chk("glitch_irq", intr_src_o, '0);
      end

      src[3] = 1'b1;
      repeat (L) tick("pulse");
      chk("pulse_lvl3_up", 32'(src_level_o[3]), 32'd1);
      src[3] = 1'b0;
      for (int k = 1; k <= L; k++) begin
         tick("pulse_fall");
         chk("pulse_lvl3_dn", 32'(src_level_o[3]), 32'(k < L));
      end

      src[7] = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick("edge_hi");
         chk("edge_irq7", 32'(intr_src_o[7]), 32'(k == L));
      end
      src[7] = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick("edge_lo");
         chk("edge_fall_irq7", 32'(intr_src_o[7]), 32'd0);
      end

      en[3]  = 1'b0;
      src[3] = 1'b1;
      repeat (L + 1) tick("dis_lvl");
      chk("dis_lvl3", 32'(src_level_o[3]), 32'd1);
      chk("dis_irq3", 32'(intr_src_o[3]), 32'd0);
      en[3] = 1'b1;
      #1;
      chk("en_same_cycle_irq3", 32'(intr_src_o[3]), 32'd1);
      en[7]  = 1'b0;
      src[7] = 1'b1;
      repeat (L + 1) tick("dis_edge");
      en[7] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick("reen_edge");
         chk("reen_irq7", 32'(intr_src_o[7]), 32'd0);
      end
      src = '0;
      repeat (L + 1) tick("clear");

      src[3] = 1'b1;
      repeat (3) tick("pre_rst");
      reset_now("mid_rst");
      repeat (2) tick("mid_rst_hold");
      rst = 1'b0;
      for (int k = 1; k <= L; k++) begin
         tick("post_rst");
         chk("post_rst_lvl3", 32'(src_level_o[3]), 32'(k == L));
      end

      src = '0;
      repeat (L + 1) tick("clear2");
      src = '1;
      for (int k = 1; k <= L; k++) begin
         tick("all");
         chk("all_lvl", src_level_o, (k == L) ? 32'hFFFF_FFFF : 32'h0);
      end

      for (int c = 0; c < 600; c++) begin
         src = src ^ ($urandom & $urandom & $urandom);
         if ($urandom_range(0, 15) == 0) en = $urandom;
         if ($urandom_range(0, 149) == 0) begin
            reset_now("rand_rst");
            tick("rand_rst_hold");
            rst = 1'b0;
         end
         tick("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
